// File: rtl/add_sub_64_pkg.sv
// Shared ALU definitions: datapath width, operation encodings and the
// carry-lookahead helper equations used by the add/sub core.
package add_sub_64_pkg;

   localparam int XLEN    = 64;
   localparam int BLK_W   = 16;
   localparam int NUM_BLK = XLEN / BLK_W;

   // Operation select carried on the 1-bit mode input.
   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } op_e;

   // Carries into positions 0..3 of a 4-wide lookahead group. Position 3's
   // own generate/propagate never influences carries inside the group.
   function automatic logic [3:0] lookahead4(input logic [2:0] g,
                                             input logic [2:0] p,
                                             input logic       cin);
      logic [3:0] c;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      return c;
   endfunction

   // Group generate of four positions. Position 0's propagate cannot matter
   // because nothing below it generates inside the group.
   function automatic logic group_gen(input logic [3:0] g,
                                      input logic [3:1] p_hi);
      return g[3] | (p_hi[3] & g[2]) | (p_hi[3] & p_hi[2] & g[1]) |
             (p_hi[3] & p_hi[2] & p_hi[1] & g[0]);
   endfunction

endpackage

// File: rtl/add_sub_64_cla_16.sv
// 16-bit two-level carry-lookahead adder slice: four 4-bit lookahead groups
// under a second lookahead level. Exposes block generate/propagate so the
// parent can resolve carries between slices without waiting on this one.
module cla_16
   import add_sub_64_pkg::*;
(
   input  logic [BLK_W-1:0] a_i,
   input  logic [BLK_W-1:0] b_i,
   input  logic             cin_i,
   output logic [BLK_W-1:0] sum_o,
   output logic             grp_p_o,
   output logic             grp_g_o
);

   logic [BLK_W-1:0] g;
   logic [BLK_W-1:0] p;
   logic [BLK_W-1:0] c;
   logic [3:0]       gg;
   logic [3:0]       gp;
   logic [3:0]       gc;

   // Bit and group generate/propagate; kept free of cin_i so block P/G never
   // depends on the incoming carry.
   // NOTE: every variable written here gets a value on every pass; a path that
   // leaves one unassigned makes synthesis infer a latch.
   always_comb begin
      g  = a_i & b_i;
      p  = a_i ^ b_i;
      gg = '0;
      gp = '0;
      for (int k = 0; k < 4; k++) begin
         gg[k] = group_gen(g[4*k +: 4], p[4*k+1 +: 3]);
         gp[k] = &p[4*k +: 4];
      end
   end

   // Carries into each group from cin_i, then carries into each bit.
   always_comb begin
      c  = '0;
      gc = lookahead4(gg[2:0], gp[2:0], cin_i);
      for (int k = 0; k < 4; k++) begin
         c[4*k +: 4] = lookahead4(g[4*k +: 3], p[4*k +: 3], gc[k]);
      end
   end

   assign sum_o   = p ^ c;
   assign grp_g_o = group_gen(gg, gp[3:1]);
   assign grp_p_o = &gp;

endmodule

// File: rtl/add_sub_64.sv
// 64-bit add/subtract datapath with registered result and carry/overflow
// flags. Subtraction is a + ~b + 1; one operation per cycle, 1-cycle latency.
module add_sub_64
   import add_sub_64_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            mode,
   output logic [XLEN-1:0] s,
   output logic            carry_flag,
   output logic            overflow_flag
);

   logic               sub_op;
   logic [XLEN-1:0]    b_eff;
   logic [XLEN-1:0]    sum;
   logic [NUM_BLK-1:0] blk_g;
   logic [NUM_BLK-1:0] blk_p;
   logic [NUM_BLK-1:0] blk_c;
   logic               cout;
   logic               c_msb;

   logic [XLEN-1:0]    s_q,     s_d;
   logic               carry_q, carry_d;
   logic               ovf_q,   ovf_d;

   assign sub_op = (op_e'(mode) == SUB);
   assign b_eff  = b ^ {XLEN{sub_op}};

   // Third lookahead level: carries into each 16-bit slice and out of bit 63,
   // all from slice P/G and the operation carry-in.
   assign blk_c = lookahead4(blk_g[2:0], blk_p[2:0], sub_op);
   assign cout  = group_gen(blk_g, blk_p[3:1]) | ((&blk_p) & sub_op);

   for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
      cla_16 u_cla (
         .a_i     (a[k*BLK_W +: BLK_W]),
         .b_i     (b_eff[k*BLK_W +: BLK_W]),
         .cin_i   (blk_c[k]),
         .sum_o   (sum[k*BLK_W +: BLK_W]),
         .grp_p_o (blk_p[k]),
         .grp_g_o (blk_g[k])
      );
   end

   // Carry into bit 63 recovered from that bit's sum: sum = a ^ b ^ cin.
   assign c_msb = sum[XLEN-1] ^ a[XLEN-1] ^ b_eff[XLEN-1];

   // Next-state values for the output registers.
   always_comb begin
      s_d     = sum;
      carry_d = cout;
      ovf_d   = c_msb ^ cout;
   end

   // Output registers; reset clears them immediately, dropping any in-flight result.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         s_q     <= s_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign s             = s_q;
   assign carry_flag    = carry_q;
   assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_add_sub_64.sv
// Self-checking bench for add_sub_64: directed edge cases with literal
// expectations, asynchronous reset mid-stream, and a back-to-back random run
// with mode toggling every cycle against a 65-bit arithmetic reference.
module tb_add_sub_64;
   import add_sub_64_pkg::*;

   logic            clk;
   logic            rst_n;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            mode;
   logic [XLEN-1:0] s;
   logic            carry_flag;
   logic            overflow_flag;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [XLEN-1:0] s;
      logic            c;
      logic            v;
      string           tag;
   } exp_t;

   exp_t sb[$];

   add_sub_64 dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .a             (a),
      .b             (b),
      .mode          (mode),
      .s             (s),
      .carry_flag    (carry_flag),
      .overflow_flag (overflow_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-width arithmetic; overflow from operand/result signs.
   function automatic exp_t model(input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                                  input logic m);
      exp_t            e;
      logic [XLEN:0]   r;
      logic [XLEN-1:0] be;
      be    = m ? ~bv : bv;
      r     = {1'b0, av} + {1'b0, be} + {{XLEN{1'b0}}, m};
      e.s   = r[XLEN-1:0];
      e.c   = r[XLEN];
      e.v   = (av[XLEN-1] == be[XLEN-1]) && (r[XLEN-1] != av[XLEN-1]);
      e.tag = "rand";
      return e;
   endfunction

   task automatic check(input string tag, input logic [XLEN-1:0] es,
                        input logic ec, input logic ev);
      checks++;
      assert ({s, carry_flag, overflow_flag} === {es, ec, ev})
      else begin
         errors++;
         $error("FAIL %s: got s=%h c=%b v=%b, expected s=%h c=%b v=%b",
                tag, s, carry_flag, overflow_flag, es, ec, ev);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard: got empty queue, expected a pending result");
      end else begin
         e = sb.pop_front();
         check(e.tag, e.s, e.c, e.v);
      end
   endtask

   // Drive one operation away from the edge, queue its expectation, and
   // compare once the capturing edge has passed.
   task automatic issue(input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                        input logic m, input exp_t e);
      @(negedge clk);
      a    = av;
      b    = bv;
      mode = m;
      sb.push_back(e);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic directed(input string tag, input logic [XLEN-1:0] av,
                           input logic [XLEN-1:0] bv, input logic m,
                           input logic [XLEN-1:0] es, input logic ec, input logic ev);
      exp_t e;
      e = '{s: es, c: ec, v: ev, tag: tag};
      issue(av, bv, m, e);
   endtask

   initial begin
      rst_n = 1'b0;
      a     = '0;
      b     = '0;
      mode  = ADD;
      #1;
      check("reset_init", '0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      directed("add_2_3",     64'd2, 64'd3, ADD, 64'd5, 1'b0, 1'b0);
      directed("add_2p30",    64'h0000_0000_4000_0000, 64'h0000_0000_4000_0000, ADD,
               64'h0000_0000_8000_0000, 1'b0, 1'b0);
      directed("add_max_m1",  64'h7FFF_FFFF_FFFF_FFFE, 64'd1, ADD,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      directed("add_sovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ADD,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
      directed("add_uovf",    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ADD, 64'd0, 1'b1, 1'b0);
      directed("sub_7_5",     64'd7, 64'd5, SUB, 64'd2, 1'b1, 1'b0);
      directed("sub_5_7",     64'd5, 64'd7, SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      directed("sub_neg",     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB, SUB,
               64'd2, 1'b1, 1'b0);
      directed("sub_zero",    64'h1234_5678_9ABC_DEF0, 64'd0, SUB,
               64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
      directed("sub_min_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, SUB,
               64'd0, 1'b1, 1'b0);
      directed("sub_sovf",    64'h8000_0000_0000_0000, 64'd1, SUB,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // Reset while an operation is in flight: all outputs were nonzero.
      @(negedge clk);
      a     = 64'd7;
      b     = 64'd5;
      mode  = SUB;
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", '0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_hold", '0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      directed("after_reset", 64'd7, 64'd5, SUB, 64'd2, 1'b1, 1'b0);

      // Back-to-back random operations, mode alternating every cycle.
      for (int i = 0; i < 10000; i++) begin
         logic [XLEN-1:0] ra;
         logic [XLEN-1:0] rb;
         logic            rm;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rm = i[0];
         issue(ra, rb, rm, model(ra, rb, rm));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/add_sub_64.md
# add_sub_64

64-bit two's-complement adder/subtractor with registered sum and carry/overflow flags. It is the integer add/sub datapath of the ALU: one operation per clock, with results presented one cycle after the operands. `mode` selects between a + b and a − b. Subtraction is computed as a + ~b + 1.

## Interface
Parameters:
- none; width is fixed at 64.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  64  operand A.
- b  input  64  operand B.
- mode  input  1  operation select: 0 = add (a + b), 1 = subtract (a − b).
- s  output  64  registered result, modulo 2^64.
- carry_flag  output  1  registered carry-out of bit 63.
- overflow_flag  output  1  registered signed (two's-complement) overflow.

## Operation
- Effective operand: b_eff = b XOR {64{mode}}.
- Carry-in: cin = mode.
- Raw result: {cout, sum} = a + b_eff + cin, a 65-bit result; sum is truncated to 64 bits.
- carry_flag = cout.
  - Add: 1 means unsigned overflow.
  - Subtract: 1 means no borrow (a ≥ b unsigned); 0 means borrow.
- overflow_flag = carry into bit 63 XOR carry out of bit 63. This is equivalent to (a[63] == b_eff[63]) && (sum[63] != a[63]).
- Operands are treated the same way whether interpreted as signed or unsigned; only the flag interpretation differs.
- No saturation; results wrap modulo 2^64.
- a − 0 with mode=1 yields s = a and carry_flag = 1.
- 0x8000_0000_0000_0000 − 0x8000_0000_0000_0000 yields s = 0, carry_flag = 1, overflow_flag = 0.

## Timing
- The core is purely combinational. s, carry_flag and overflow_flag are captured on the rising edge of clk.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Throughput: one new operation every cycle; there is no handshake and no stall.
- Reset: while rst_n = 0, s = 0, carry_flag = 0 and overflow_flag = 0, asynchronously and regardless of clk.
- Deassertion of rst_n is synchronised externally. The first capture happens at the first rising edge with rst_n = 1.
- Reset mid-operation: outputs clear immediately and the in-flight result is discarded. No state exists other than the output registers.
- Changing `mode` and the operands on the same edge is legal; the captured result uses all values sampled at that edge.
- The combinational path a/b/mode → register D must close timing at the ALU clock.

## Structure
- Core: four 16-bit carry-lookahead blocks chained by block carry, built from 4-bit CLA groups with generate/propagate. A ripple chain is acceptable only if timing allows.
- The carry into bit 63 must be exposed internally for overflow_flag.
- Shared ALU package:
  - width constant XLEN = 64;
  - mode encodings ADD = 1'b0 and SUB = 1'b1.
- One sub-module is natural: cla_16 (16-bit CLA with cin, sum, cout, group P/G). It is instantiated four times inside add_sub_64.
- The output register stage lives in the top module.

## Test plan
Check each result one cycle after applying the operands.
- Reset: assert rst_n = 0 mid-stream → s = 0, carry_flag = 0, overflow_flag = 0 immediately; the next operation after release is correct.
- Add, small and edge values:
  - 2 + 3 → s = 5, c = 0, v = 0.
  - 2^30 + 2^30 → s = 0x0000_0000_8000_0000, c = 0, v = 0.
  - 0x7FFF_FFFF_FFFF_FFFE + 1 → s = 0x7FFF_FFFF_FFFF_FFFF, c = 0, v = 0.
- Add, signed overflow:
  - 0x7FFF_FFFF_FFFF_FFFF + 1 → s = 0x8000_0000_0000_0000, c = 0, v = 1.
  - 0xFFFF_FFFF_FFFF_FFFF + 1 → s = 0, c = 1, v = 0.
- Subtract:
  - 7 − 5 → s = 2, c = 1, v = 0.
  - 5 − 7 → s = 0xFFFF_FFFF_FFFF_FFFE, c = 0, v = 0.
- Subtract, negative operands: (−3) − (−5), i.e. 0xFFFF_FFFF_FFFF_FFFD − 0xFFFF_FFFF_FFFF_FFFB → s = 2, c = 1, v = 0.
- Subtract, overflow: 0x8000_0000_0000_0000 − 1 → s = 0x7FFF_FFFF_FFFF_FFFF, c = 1, v = 1.
- Back-to-back: toggle mode every cycle with random operands → each output matches the reference model of the previous cycle's inputs; run ≥10k random vectors.
